// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, address-field helpers and FSM state codes for icache
package icache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic int off_bits(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int wpl);
    return ADDR_W - 2 - $clog2(lines) - $clog2(wpl);
  endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and refill-side signal bundle of the instruction cache
interface icache_if;
  import icache_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] instr;
  logic              stall;
  logic              inv;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, inv, mem_valid, mem_rdata,
    output instr, stall, mem_req, mem_addr
  );

  modport master (
    output req_valid, req_addr, inv, mem_valid, mem_rdata,
    input  instr, stall, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_store.sv
// rtl/icache_store.sv - valid/tag/data arrays with combinational read and registered write
module icache_store
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int IW    = 4,
  parameter int OW    = 2,
  parameter int TW    = 24
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [IW-1:0]     rd_idx_i,
  input  logic [OW-1:0]     rd_off_i,
  output logic              rd_valid_o,
  output logic [TW-1:0]     rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [OW-1:0]     wr_off_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              set_valid_i,
  input  logic [TW-1:0]     wr_tag_i,
  input  logic              clr_i
);

  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WPL];

  // Bulk clear has priority so an invalidate on the final refill beat leaves the line invalid.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
    if (set_valid_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with whole-line refill
module icache
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WPL   = 4
) (
  input  logic     clock,
  input  logic     rst,
  icache_if.slave  bus
);

  localparam int OW  = off_bits(WPL);
  localparam int IW  = idx_bits(LINES);
  localparam int TW  = tag_bits(LINES, WPL);
  localparam int OLO = 2;
  localparam int ILO = OLO + OW;
  localparam int TLO = ILO + IW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(WPL - 1);

  logic [1:0]        state_q, state_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              rd_valid;
  logic [TW-1:0]     rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit, miss, beat_fire, last_beat;
  logic              unused_bits;

  assign hit       = bus.req_valid && (state_q == ST_IDLE) && rd_valid
                     && (rd_tag == bus.req_addr[ADDR_W-1:TLO]);
  assign miss      = bus.req_valid && (state_q == ST_IDLE) && !hit;
  assign beat_fire = (state_q == ST_REFILL) && bus.mem_valid;
  assign last_beat = beat_fire && (beat_q == LAST_BEAT);

  assign bus.instr    = rd_data;
  assign bus.stall    = (bus.req_valid && !hit) || (state_q != ST_IDLE);
  assign bus.mem_req  = (state_q == ST_REFILL);
  assign bus.mem_addr = mem_addr_q;
  assign unused_bits  = ^bus.req_addr[OLO-1:0];

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          state_d    = ST_REFILL;
          beat_d     = '0;
          mem_addr_d = {bus.req_addr[ADDR_W-1:ILO], {ILO{1'b0}}};
        end
      end
      ST_REFILL: begin
        if (beat_fire) begin
          beat_d = beat_q + OW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      // DONE exists only to force one clean re-lookup against the freshly written line.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  icache_store #(
    .LINES (LINES),
    .WPL   (WPL),
    .IW    (IW),
    .OW    (OW),
    .TW    (TW)
  ) u_store (
    .clock       (clock),
    .rst         (rst),
    .rd_idx_i    (bus.req_addr[TLO-1:ILO]),
    .rd_off_i    (bus.req_addr[ILO-1:OLO]),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (beat_fire),
    .wr_idx_i    (mem_addr_q[TLO-1:ILO]),
    .wr_off_i    (beat_q),
    .wr_data_i   (bus.mem_rdata),
    .set_valid_i (last_beat),
    .wr_tag_i    (mem_addr_q[ADDR_W-1:TLO]),
    .clr_i       (bus.inv)
  );

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache against a line-table and memory-image model
module tb_icache;

  localparam int LINES = 16;
  localparam int WPL   = 4;
  localparam int LINE_BYTES = 4 * WPL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_if bus();

  icache #(.LINES(LINES), .WPL(WPL)) dut (
    .clock (clk),
    .rst   (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  bit          mv [LINES];
  logic [31:0] mt [LINES];

  int   mem_mode = 0;
  int   resp_beat = 0;
  int   slow_cnt = 0;
  bit   inv_on_last = 1'b0;
  logic inv_main = 1'b0;
  logic inv_resp = 1'b0;

  assign bus.inv = inv_main | inv_resp;

  typedef struct {
    logic [31:0] addr;
    logic        exp_stall;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h4) return 32'hA0 + 32'(a[3:2]);
    return (a * 32'h9E37_79B9) ^ 32'h5555_0000;
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] line_tag(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    mv[line_idx(a)] = 1'b1;
    mt[line_idx(a)] = line_tag(a);
  endtask

  // Memory responder: serves words of the latched line in order, optionally with gaps.
  initial begin
    bit give;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      inv_resp = 1'b0;
      if (bus.mem_req) begin
        case (mem_mode)
          0: give = 1'b1;
          1: begin slow_cnt++; give = (slow_cnt % 3 == 0); end
          default: give = 1'($urandom_range(0, 1));
        endcase
        bus.mem_valid = give;
        if (give) begin
          bus.mem_rdata = mem_word(bus.mem_addr + 32'(4 * resp_beat));
          if (inv_on_last && resp_beat == WPL - 1) inv_resp = 1'b1;
          resp_beat++;
        end else begin
          bus.mem_rdata = $urandom;
        end
      end else begin
        resp_beat = 0;
        slow_cnt = 0;
        if (mem_mode == 2) begin
          bus.mem_valid = 1'($urandom_range(0, 1));
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_valid = 1'b0;
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a);
    bit ph, done;
    int cyc, stalls, waits, beats, last_cyc;
    logic [31:0] base;
    ph = mv[line_idx(a)] && (mt[line_idx(a)] == line_tag(a));
    base = a & ~32'(LINE_BYTES - 1);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    cyc = 0; stalls = 0; waits = 0; beats = 0; last_cyc = -1; done = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) chk("first_stall", 32'(bus.stall), 32'(!ph));
      if (bus.mem_req) begin
        chk("mem_addr", bus.mem_addr, base);
        if (bus.mem_valid) begin beats++; last_cyc = cyc; end
        else waits++;
      end
      if (!bus.stall) begin
        chk("instr", bus.instr, mem_word(a));
        done = 1'b1;
      end else begin
        stalls++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (!done) begin
      chk("fetch_timeout", 32'(cyc), 32'd0);
    end else if (!ph) begin
      chk("stall_cycles", 32'(stalls), 32'(WPL + 2 + waits));
      chk("beats", 32'(beats), 32'(WPL));
      chk("release_after_last", 32'(cyc - 1 - last_cyc), 32'd2);
      model_fill(a);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_mem_req(input logic want, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.mem_req !== want && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.mem_req), 32'(want));
  endtask

  task automatic pulse_inv();
    bus.req_valid = 1'b0;
    inv_main = 1'b1;
    @(posedge clk); #1;
    inv_main = 1'b0;
    model_clear();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    model_clear();

    tbl[0] = '{32'h0000_0040, 1'b0, 32'h0000_00A0};
    tbl[1] = '{32'h0000_0044, 1'b0, 32'h0000_00A1};
    tbl[2] = '{32'h0000_0048, 1'b0, 32'h0000_00A2};
    tbl[3] = '{32'h0000_004C, 1'b0, 32'h0000_00A3};

    #2;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    bus.req_valid = 1'b1;
    #1;
    chk("rst_stall_req", 32'(bus.stall), 32'd1);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_fetch(32'h0000_0040);

    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr = tbl[i].addr;
      @(negedge clk);
      chk("tbl_stall", 32'(bus.stall), 32'(tbl[i].exp_stall));
      chk("tbl_instr", bus.instr, tbl[i].exp_instr);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;

    do_fetch(32'h0000_0140);
    do_fetch(32'h0000_0040);

    mem_mode = 1;
    do_fetch(32'h0000_01C8);
    mem_mode = 0;

    inv_on_last = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_0084;
    wait_mem_req(1'b1, "invlast_req_rise");
    wait_mem_req(1'b0, "invlast_req_fall");
    chk("invlast_done_stall", 32'(bus.stall), 32'd1);
    inv_on_last = 1'b0;
    @(negedge clk);
    chk("invlast_relookup_stall", 32'(bus.stall), 32'd1);
    chk("invlast_relookup_idle", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk("invlast_second_refill", 32'(bus.mem_req), 32'd1);
    wait_mem_req(1'b0, "invlast_second_fall");
    @(negedge clk);
    chk("invlast_final_stall", 32'(bus.stall), 32'd0);
    chk("invlast_final_instr", bus.instr, mem_word(32'h0000_0084));
    model_clear();
    model_fill(32'h0000_0084);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    do_fetch(32'h0000_0084);
    pulse_inv();
    do_fetch(32'h0000_0084);

    do_fetch(32'h0000_0040);
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_02C0;
    wait_mem_req(1'b1, "rstmid_req_rise");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstmid_stall", 32'(bus.stall), 32'd1);
    bus.req_valid = 1'b0;
    #1;
    chk("rstmid_stall_idle", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    do_fetch(32'h0000_02C0);
    do_fetch(32'h0000_0040);

    mem_mode = 2;
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) pulse_inv();
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      do_fetch(a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
